branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Resolution-side companion to the 2-bit branch predictor: buffers in-flight predictions in issue order, matches each against the actual branch outcome when it resolves, and emits the `taken` update stream that trains the predictor. Flags mispredictions, flushes wrong-path predictions, holds off new issues during a recovery window, and keeps saturating accuracy counters. Sits between the predictor/fetch side and the branch execute stage.

## Interface
- `DEPTH`, 4: prediction FIFO entries (power of two, ≥2).
- `RECOVER_CYCLES`, 2: cycles `pred_ready` is held low after a mispredict (≥1).
- `CNT_W`, 16: width of the statistics counters.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pred_valid`  in  1  a prediction is being issued this cycle.
- `pred_bit`  in  1  predicted direction (1 = taken).
- `pred_ready`  out  1  FIFO can accept a prediction; combinational from state and occupancy.
- `res_valid`  in  1  oldest outstanding branch resolves this cycle.
- `res_taken`  in  1  actual direction.
- `upd_valid`  out  1  registered; one-cycle pulse, predictor update.
- `upd_taken`  out  1  registered; actual direction for the update. Feeds the predictor's `taken`.
- `mispredict`  out  1  registered; one-cycle pulse, prediction ≠ outcome.
- `occupancy`  out  $clog2(DEPTH)+1  entries currently held.
- `branch_count`  out  CNT_W  resolved branches, saturating.
- `miss_count`  out  CNT_W  mispredicted branches, saturating.
- `underflow_err`  out  1  sticky; `res_valid` seen with FIFO empty.

## Operation
- Push: `pred_valid && pred_ready` writes `pred_bit` at the tail.
- `pred_ready = (state == RUN) && (occupancy < DEPTH)`.
- Pop: `res_valid && occupancy != 0` reads the head, compares with `res_taken`, and removes the head.
- `res_valid` with `occupancy == 0`: ignored. No update and no counter change. Sets `underflow_err`, which holds until reset.
- Push and pop in the same cycle with no mispredict: occupancy unchanged, order preserved. Legal at any occupancy, including DEPTH-1 and 1.
- Every valid pop:
  - `upd_valid`=1 and `upd_taken`=`res_taken` on the next cycle.
  - `branch_count` +1, saturating at 2^CNT_W−1.
- Pop with head ≠ `res_taken`:
  - `mispredict`=1 on the next cycle.
  - `miss_count` +1, saturating.
  - Whole FIFO is cleared at that edge, including any same-cycle push; occupancy becomes 0.
  - FSM enters RECOVER.
- FSM states:
  - RUN: normal operation.
  - RECOVER: a down-counter is loaded with RECOVER_CYCLES. `pred_ready`=0. Pops are not possible because the FIFO is empty; `res_valid` in RECOVER behaves as underflow. Returns to RUN when the counter reaches 0.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by `occupancy`, not by pointer equality.

## Timing
- Reset (synchronous, `reset`=1 at an edge), values after that edge:
  - occupancy 0, pointers 0, state RUN.
  - `upd_valid`, `upd_taken`, `mispredict`, `underflow_err` all 0; counters 0.
  - Consequently `pred_ready`=1.
- Reset mid-operation (any state, any occupancy): same result at that edge. Pending entries are discarded and no update pulse follows.
- Latency:
  - Resolve to `upd_valid`/`mispredict`: 1 cycle.
  - Counters show the new value 1 cycle after the resolve.
- Push-to-resolve: an entry pushed at edge N can be popped by `res_valid` sampled at edge N+1 or later. Same-cycle push and pop on an empty FIFO is underflow.
- Recovery window: mispredict resolve at edge N; `pred_ready`=0 for cycles N+1 … N+RECOVER_CYCLES; 1 again from cycle N+RECOVER_CYCLES+1 (if not reset).
- Outputs pulse for exactly one cycle per pop; back-to-back pops give back-to-back pulses.

## Test plan
- Reset: assert `reset` 2 cycles after arbitrary traffic → occupancy 0, `pred_ready`=1, counters 0, `underflow_err`=0, no pulses.
- Fill, then drain correctly:
  - Push 1,0,1,1 (DEPTH=4) → `pred_ready`=0 at occupancy 4.
  - Resolve 1,0,1,1 → 4 `upd_valid` pulses with `upd_taken`=1,0,1,1; `mispredict` never high.
  - branch_count=4, miss_count=0.
- Mispredict flush:
  - Push 1,1,1; resolve first with 0, pushing 0 in the same cycle.
  - → `mispredict` and `upd_taken`=0 next cycle; occupancy 0; miss_count=1.
  - `pred_ready` low for exactly 2 cycles, then high.
- Simultaneous push/pop at occupancy 2 for 10 cycles with matching outcomes → occupancy stays 2, 10 update pulses in FIFO order, pointers wrap cleanly.
- Underflow: `res_valid`=1 with an empty FIFO → `underflow_err`=1 and stays 1; no `upd_valid`; branch_count unchanged.
- Saturation: CNT_W=3, 9 mispredicting resolves (push between each recovery) → branch_count=7, miss_count=7.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: matches issued branch predictions against resolved
// outcomes in issue order, trains the predictor, flushes on mispredict and
// keeps saturating accuracy statistics.
module branch_resolve_unit #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic                       pred_bit,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       upd_valid,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           branch_count,
    output logic [CNT_W-1:0]           miss_count,
    output logic                       underflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned RC_W  = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t              state;
    logic [RC_W-1:0]     rec_cnt;
    logic [DEPTH-1:0]    fifo_mem;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    logic                push;
    logic                pop;
    logic                head_bit;
    logic                miss;

    // Handshake and resolve qualification; a miss only exists on a real pop.
    assign pred_ready = (state == RUN) && (occupancy < OCC_W'(DEPTH));
    assign push       = pred_valid && pred_ready;
    assign pop        = res_valid && (occupancy != '0);
    assign head_bit   = fifo_mem[rd_ptr];
    assign miss       = pop && (head_bit != res_taken);

    // Prediction storage; contents are meaningless beyond occupancy so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pred_bit;
        end
    end

    // Pointers, occupancy, update pulses, statistics and the recovery FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            rec_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            upd_valid     <= 1'b0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            underflow_err <= 1'b0;
            branch_count  <= '0;
            miss_count    <= '0;
        end else begin
            upd_valid  <= pop;
            upd_taken  <= pop ? res_taken : 1'b0;
            mispredict <= miss;

            if (res_valid && (occupancy == '0)) begin
                underflow_err <= 1'b1;
            end

            if (pop && (branch_count != {CNT_W{1'b1}})) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (miss && (miss_count != {CNT_W{1'b1}})) begin
                miss_count <= miss_count + CNT_W'(1);
            end

            // A mispredict discards every queued prediction, including a same-cycle push.
            if (miss) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   occupancy <= occupancy + OCC_W'(1);
                    2'b01:   occupancy <= occupancy - OCC_W'(1);
                    default: occupancy <= occupancy;
                endcase
            end

            case (state)
                RUN: begin
                    if (miss) begin
                        state   <= RECOVER;
                        rec_cnt <= RC_W'(RECOVER_CYCLES);
                    end
                end
                RECOVER: begin
                    rec_cnt <= rec_cnt - RC_W'(1);
                    if (rec_cnt == RC_W'(1)) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit (DEPTH=4, RECOVER_CYCLES=2, CNT_W=3).
module tb_branch_resolve_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RC    = 2;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             pred_valid;
    logic             pred_bit;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             upd_valid;
    logic             upd_taken;
    logic             mispredict;
    logic [2:0]       occupancy;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] miss_count;
    logic             underflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_unit #(
        .DEPTH(DEPTH),
        .RECOVER_CYCLES(RC),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pred_valid(pred_valid),
        .pred_bit(pred_bit),
        .pred_ready(pred_ready),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .upd_valid(upd_valid),
        .upd_taken(upd_taken),
        .mispredict(mispredict),
        .occupancy(occupancy),
        .branch_count(branch_count),
        .miss_count(miss_count),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample just after the rising edge.
    task automatic cyc(input logic rst, input logic pv, input logic pb, input logic rv, input logic rt);
        reset      = rst;
        pred_valid = pv;
        pred_bit   = pb;
        res_valid  = rv;
        res_taken  = rt;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        pred_valid = 1'b0;
        pred_bit   = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        #1;
    endtask

    logic [3:0] fill_pat;
    logic [9:0] pp_pat;
    logic       q[$];
    logic       exp_bit;

    initial begin
        reset = 1'b0; pred_valid = 1'b0; pred_bit = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
        #2;

        // Reset from power-up
        cyc(1, 0, 0, 0, 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_ready", 32'(pred_ready), 1);
        check("rst_bc", 32'(branch_count), 0);
        check("rst_uf", 32'(underflow_err), 0);

        // Fill with 1,0,1,1 then drain correctly
        fill_pat = 4'b1101;
        for (int i = 0; i < 4; i++) cyc(0, 1, fill_pat[i], 0, 0);
        check("fill_occ", 32'(occupancy), 4);
        check("fill_ready", 32'(pred_ready), 0);
        cyc(0, 1, 0, 0, 0);
        check("full_push_ignored", 32'(occupancy), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, fill_pat[i]);
            check("drain_upd_valid", 32'(upd_valid), 1);
            check("drain_upd_taken", 32'(upd_taken), 32'(fill_pat[i]));
            check("drain_mispredict", 32'(mispredict), 0);
        end
        check("drain_bc", 32'(branch_count), 4);
        check("drain_mc", 32'(miss_count), 0);
        check("drain_occ", 32'(occupancy), 0);
        cyc(0, 0, 0, 0, 0);
        check("drain_pulse_end", 32'(upd_valid), 0);

        // Reset mid-operation with a pending resolve: nothing follows
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 1);
        check("midrst_occ", 32'(occupancy), 0);
        check("midrst_upd", 32'(upd_valid), 0);
        check("midrst_bc", 32'(branch_count), 0);
        check("midrst_ready", 32'(pred_ready), 1);
        cyc(0, 0, 0, 0, 0);
        check("midrst_upd2", 32'(upd_valid), 0);

        // Mispredict flush with a same-cycle push, then recovery window
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        check("mp_mispredict", 32'(mispredict), 1);
        check("mp_upd_valid", 32'(upd_valid), 1);
        check("mp_upd_taken", 32'(upd_taken), 0);
        check("mp_occ", 32'(occupancy), 0);
        check("mp_mc", 32'(miss_count), 1);
        check("mp_ready_c1", 32'(pred_ready), 0);
        cyc(0, 1, 1, 0, 0);
        check("mp_pulse_end", 32'(mispredict), 0);
        check("mp_recover_push", 32'(occupancy), 0);
        check("mp_ready_c2", 32'(pred_ready), 0);
        cyc(0, 0, 0, 0, 0);
        check("mp_ready_c3", 32'(pred_ready), 1);

        // Simultaneous push/pop at occupancy 2 for 10 cycles
        cyc(1, 0, 0, 0, 0);
        q.delete();
        cyc(0, 1, 0, 0, 0); q.push_back(1'b0);
        cyc(0, 1, 1, 0, 0); q.push_back(1'b1);
        pp_pat = 10'b1101001110;
        for (int i = 0; i < 10; i++) begin
            exp_bit = q.pop_front();
            q.push_back(pp_pat[i]);
            cyc(0, 1, pp_pat[i], 1, exp_bit);
            check("pp_upd_valid", 32'(upd_valid), 1);
            check("pp_upd_taken", 32'(upd_taken), 32'(exp_bit));
            check("pp_mispredict", 32'(mispredict), 0);
            check("pp_occ", 32'(occupancy), 2);
        end
        check("pp_bc_sat", 32'(branch_count), 7);
        for (int i = 0; i < 2; i++) begin
            exp_bit = q.pop_front();
            cyc(0, 0, 0, 1, exp_bit);
            check("pp_tail_taken", 32'(upd_taken), 32'(exp_bit));
            check("pp_tail_mp", 32'(mispredict), 0);
        end
        check("pp_final_occ", 32'(occupancy), 0);

        // Underflow on an empty FIFO
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        check("uf_flag", 32'(underflow_err), 1);
        check("uf_no_upd", 32'(upd_valid), 0);
        check("uf_bc", 32'(branch_count), 0);
        cyc(0, 0, 0, 0, 0);
        check("uf_sticky", 32'(underflow_err), 1);

        // Same-cycle push and pop on empty: push lands, pop is underflow
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1);
        check("pe_uf", 32'(underflow_err), 1);
        check("pe_occ", 32'(occupancy), 1);
        check("pe_no_upd", 32'(upd_valid), 0);
        cyc(0, 0, 0, 1, 1);
        check("pe_pop_upd", 32'(upd_valid), 1);
        check("pe_pop_mp", 32'(mispredict), 0);

        // Saturation: 9 mispredicting resolves
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, 1, 0, 0);
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        check("sat_bc", 32'(branch_count), 7);
        check("sat_mc", 32'(miss_count), 7);
        check("sat_uf", 32'(underflow_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
